regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the OpenMIPS datapath, successor to the 2-read/1-write register file. It provides NRD registered read ports, two prioritised write ports with same-cycle write-to-read forwarding, and a hardware sweep that clears every register after reset. A per-register busy scoreboard lets the decode stage detect pending writes. It sits between the ID stage (reads, scoreboard set) and the WB stage (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- NRD, 3, number of read ports (1..8)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero, never busy
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- init_done  out  1  high once the post-reset clear sweep has finished
- we0 / waddr0 / wdata0  in  1 / ADDR_W / DATA_W  write port 0
- we1 / waddr1 / wdata1  in  1 / ADDR_W / DATA_W  write port 1; wins over port 0 on same address
- re  in  NRD  per-port read enable
- raddr  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  registered read data; port i at bits [i*DATA_W +: DATA_W]
- rbusy  out  NRD  registered busy flag for each read port's address
- sb_set  in  1  mark register sb_addr busy (instruction issued with that destination)
- sb_addr  in  ADDR_W  scoreboard set address

## Operation
- State machine, two states: CLEAR, RUN.
- rst=1: state <= CLEAR, sweep index <= 0, busy vector <= 0, rdata <= 0, rbusy <= 0, init_done <= 0.
- CLEAR: each cycle writes 0 to regs[index], index increments; at index DEPTH-1 the state moves to RUN and init_done <= 1 on the same edge. This takes DEPTH cycles after rst falls.
- CLEAR: we0/we1/sb_set are ignored. rdata and rbusy are driven to 0.
- rst asserted during CLEAR or RUN restarts the sweep from index 0.
- RUN writes: we0 writes wdata0 to waddr0 and we1 writes wdata1 to waddr1. If both target the same address, wdata1 is stored. Writes to address 0 are dropped when ZERO_REG=1.
- RUN reads, per port i, priority order:
  - re[i]=0 gives 0.
  - Address 0 with ZERO_REG=1 gives 0.
  - A match on we1/waddr1 gives wdata1.
  - A match on we0/waddr0 gives wdata0.
  - Otherwise regs[raddr_i].
- Scoreboard:
  - busy[a] is cleared by any enabled write to a.
  - busy[a] is set by sb_set with sb_addr=a.
  - Set and clear of the same address in one cycle leaves it set; the new issue wins.
  - sb_set to address 0 is ignored when ZERO_REG=1.
- rbusy[i] is registered and equals the post-update busy value of raddr_i, so it includes this cycle's set and clear. rbusy[i] is 0 when re[i]=0.

## Timing
- Read latency is 1 cycle. raddr and re are sampled at edge N, and rdata/rbusy are valid after edge N until edge N+1.
- Write latency is 1 cycle. A read presented at cycle N+1 sees data written at edge N through the array; same-cycle reads see it through forwarding.
- There are no back-pressure or stall inputs. Every port accepts a request every RUN cycle.
- Outputs after reset: rdata=0, rbusy=0, init_done=0 until DEPTH cycles after rst deasserts.

## Test plan
- Reset sweep: preload regs via writes, pulse rst for 1 cycle. Then:
  - init_done stays low for exactly 32 cycles (DEPTH=32) and rises on the 32nd edge.
  - Writes during the sweep are ignored.
  - Every read afterwards returns 0x00000000.
- Forwarding and priority: in one cycle, we0=1 waddr0=5 wdata0=0x1111 and we1=1 waddr1=5 wdata1=0x2222, with raddr port0=5 re=1. Required: rdata port0=0x2222 next cycle, and a later read of r5 returns 0x2222.
- Zero register: write 0xDEADBEEF to r0 and sb_set r0, then read r0 on all ports. Required: rdata=0 and rbusy=0.
- Scoreboard: sb_set r7, then read r7 and expect rbusy=1. Then in one cycle apply we0 to r7 with sb_set r7 and expect rbusy stays 1. Then a write to r7 alone, and rbusy=0 on the next read.
- Multi-port independence: with NRD=3, write r1=0xA, r2=0xB, r3=0xC, then read r3,r1,r2 in one cycle with re=3'b101. Required: rdata ports = 0xC, 0, 0xB.
- Mid-operation reset: assert rst while busy r4 is set and rdata is nonzero. Required next cycle: rdata=0, rbusy=0, init_done=0, and busy r4 cleared after the sweep.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports, two prioritised write ports
// with same-cycle forwarding, post-reset clear sweep and a per-register busy scoreboard.

module regfile_mp_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] arr,
    input  logic              busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata,
    output logic              rbusy
);
    logic              zero_hit;
    logic [DATA_W-1:0] rdata_nxt;
    logic              rbusy_nxt;

    assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

    // Port 1 is checked first so its data wins when both writers hit this address.
    always_comb begin
        rdata_nxt = '0;
        rbusy_nxt = 1'b0;
        if (run && re && !zero_hit) begin
            rbusy_nxt = busy;
            if (we1 && waddr1 == raddr)      rdata_nxt = wdata1;
            else if (we0 && waddr0 == raddr) rdata_nxt = wdata0;
            else                             rdata_nxt = arr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rbusy <= 1'b0;
        end else begin
            rdata <= rdata_nxt;
            rbusy <= rbusy_nxt;
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NRD-1:0]           re,
    input  logic [NRD*ADDR_W-1:0]    raddr,
    output logic [NRD*DATA_W-1:0]    rdata,
    output logic [NRD-1:0]           rbusy,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic              run, w0_ok, w1_ok, sb_ok;

    assign run   = (state == RUN);
    assign w0_ok = run && we0 && !((ZERO_REG != 0) && waddr0 == '0);
    assign w1_ok = run && we1 && !((ZERO_REG != 0) && waddr1 == '0);
    assign sb_ok = run && sb_set && !((ZERO_REG != 0) && sb_addr == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (idx == {ADDR_W{1'b1}}) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Clears first, then the set: a new issue wins over a retiring write.
    always_comb begin
        busy_nxt = busy;
        if (run) begin
            if (we0)   busy_nxt[waddr0]  = 1'b0;
            if (we1)   busy_nxt[waddr1]  = 1'b0;
            if (sb_ok) busy_nxt[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            idx       <= '0;
            busy      <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= (state == CLEAR) ? idx + 1'b1 : idx;
            busy      <= busy_nxt;
            init_done <= (state_nxt == RUN);
        end
    end

    // Array has no reset of its own; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[idx] <= '0;
            end else begin
                if (w0_ok) regs[waddr0] <= wdata0;
                if (w1_ok) regs[waddr1] <= wdata1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];

        regfile_mp_rd #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk    (clk),
            .rst    (rst),
            .run    (run),
            .re     (re[i]),
            .raddr  (ra),
            .arr    (regs[ra]),
            .busy   (busy_nxt[ra]),
            .we0    (we0),
            .waddr0 (waddr0),
            .wdata0 (wdata0),
            .we1    (we1),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
            .rdata  (rdata[i*DATA_W +: DATA_W]),
            .rbusy  (rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table plus hand sequences for the
// reset sweep and mid-operation reset; expected reads go through a queue.

module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              init_done;
    logic              we0, we1, sb_set;
    logic [AW-1:0]     waddr0, waddr1, sb_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR-1:0]     re;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          sb;
        logic [AW-1:0] sa;
        logic [NR-1:0] re;
        logic [NR*AW-1:0] ra;
        logic [NR*DW-1:0] erd;
        logic [NR-1:0]    erb;
    } vec_t;

    typedef struct {
        string            name;
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rb;
    } exp_t;

    exp_t sb_q[$];
    int   ntot = 0;
    int   npass = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        sb_set = 0; sb_addr = '0; re = '0; raddr = '0;
    endtask

    // Drive happens before the call; expectation is queued, then checked after the edge.
    task automatic step(input bit en, input string name, input logic [NR*DW-1:0] erd,
                        input logic [NR-1:0] erb);
        exp_t e;
        if (en) begin
            e.name = name; e.rd = erd; e.rb = erb;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (en) begin
            e = sb_q.pop_front();
            check({e.name, ".rdata"}, 128'(rdata), 128'(e.rd));
            check({e.name, ".rbusy"}, 128'(rbusy), 128'(e.rb));
        end
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check({name, ".init_timeout"}, 128'(init_done), 128'(1));
    endtask

    function automatic vec_t mk(
        input logic w0, input logic [AW-1:0] a0w, input logic [DW-1:0] d0w,
        input logic w1, input logic [AW-1:0] a1w, input logic [DW-1:0] d1w,
        input logic s, input logic [AW-1:0] sa, input logic [NR-1:0] r,
        input logic [AW-1:0] ra2, input logic [AW-1:0] ra1, input logic [AW-1:0] ra0,
        input logic [DW-1:0] e2, input logic [DW-1:0] e1, input logic [DW-1:0] e0,
        input logic [NR-1:0] eb);
        vec_t v;
        v.we0 = w0; v.wa0 = a0w; v.wd0 = d0w;
        v.we1 = w1; v.wa1 = a1w; v.wd1 = d1w;
        v.sb = s; v.sa = sa; v.re = r;
        v.ra = {ra2, ra1, ra0};
        v.erd = {e2, e1, e0};
        v.erb = eb;
        return v;
    endfunction

    vec_t tbl[15];

    initial begin
        // we0 wa0 wd0 | we1 wa1 wd1 | sb sa | re | ra2 ra1 ra0 | exp d2 d1 d0 | exp busy
        tbl[0]  = mk(1, 5, 32'h1111, 1, 5, 32'h2222, 0, 0, 3'b001, 0, 0, 5, 0, 0, 32'h2222, 3'b000);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 5, 5, 5, 32'h2222, 32'h2222, 32'h2222, 3'b000);
        tbl[2]  = mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0, 3'b111, 0, 0, 0, 0, 0, 0, 3'b000);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0, 0, 0, 3'b000);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 3'b001, 0, 0, 7, 0, 0, 0, 3'b001);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 7, 7, 7, 0, 0, 0, 3'b001);
        tbl[6]  = mk(1, 7, 32'h77, 0, 0, 0, 1, 7, 3'b001, 0, 0, 7, 0, 0, 32'h77, 3'b001);
        tbl[7]  = mk(0, 0, 0, 1, 7, 32'h78, 0, 0, 3'b011, 0, 7, 7, 0, 32'h78, 32'h78, 3'b000);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 7, 0, 0, 32'h78, 3'b000);
        tbl[9]  = mk(1, 1, 32'hA, 1, 2, 32'hB, 0, 0, 3'b000, 5, 5, 5, 0, 0, 0, 3'b000);
        tbl[10] = mk(1, 3, 32'hC, 0, 0, 0, 0, 0, 3'b000, 5, 5, 5, 0, 0, 0, 3'b000);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b101, 2, 1, 3, 32'hB, 0, 32'hC, 3'b000);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 4, 3'b100, 4, 0, 0, 0, 0, 0, 3'b100);
        tbl[13] = mk(1, 4, 32'h44, 1, 6, 32'h66, 1, 4, 3'b111, 4, 6, 4, 32'h44, 32'h66, 32'h44, 3'b101);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 5, 6, 4, 32'h2222, 32'h66, 32'h44, 3'b001);

        idle();
        rst = 1;
        @(negedge clk); @(negedge clk);
        check("reset.rdata", 128'(rdata), 128'(0));
        check("reset.rbusy", 128'(rbusy), 128'(0));
        check("reset.init_done", 128'(init_done), 128'(0));
        rst = 0;
        wait_init("bringup");

        // Preload r1..r31, with r9 also issued so it ends busy
        for (int i = 1; i < 32; i++) begin
            idle();
            we0 = 1; waddr0 = AW'(i); wdata0 = 32'hA500_0000 | i;
            if (i == 9) begin sb_set = 1; sb_addr = 9; end
            step(0, "", '0, '0);
        end
        idle();
        re = 3'b001; raddr = {5'd0, 5'd0, 5'd9};
        step(1, "preload_r9", {32'h0, 32'h0, 32'hA500_0009}, 3'b001);

        rst = 1;
        step(1, "pulse_reset", '0, '0);
        check("pulse_reset.init_done", 128'(init_done), 128'(0));
        rst = 0;
        we0 = 1; waddr0 = 9; wdata0 = 32'hBAD0_0009;
        we1 = 1; waddr1 = 10; wdata1 = 32'hBAD0_000A;
        sb_set = 1; sb_addr = 9;
        re = 3'b111; raddr = {5'd9, 5'd10, 5'd9};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("sweep_init_done_%0d", k), 128'(init_done), 128'(k == 32));
            check($sformatf("sweep_rdata_%0d", k), 128'(rdata), 128'(0));
        end
        idle();
        for (int b = 0; b < 32; b += 3) begin
            re = 3'b111;
            raddr = {AW'((b + 2) % 32), AW'((b + 1) % 32), AW'(b)};
            step(1, $sformatf("cleared_%0d", b), '0, '0);
        end

        for (int v = 0; v < 15; v++) begin
            we0 = tbl[v].we0; waddr0 = tbl[v].wa0; wdata0 = tbl[v].wd0;
            we1 = tbl[v].we1; waddr1 = tbl[v].wa1; wdata1 = tbl[v].wd1;
            sb_set = tbl[v].sb; sb_addr = tbl[v].sa;
            re = tbl[v].re; raddr = tbl[v].ra;
            step(1, $sformatf("vec%0d", v), tbl[v].erd, tbl[v].erb);
        end

        // Mid-operation reset: r4 busy, outputs nonzero from the last vector
        idle();
        rst = 1; re = 3'b111; raddr = {5'd4, 5'd4, 5'd4};
        step(1, "midreset", '0, '0);
        check("midreset.init_done", 128'(init_done), 128'(0));
        rst = 0;
        idle();
        wait_init("midreset");
        re = 3'b111; raddr = {5'd4, 5'd4, 5'd4};
        step(1, "after_midreset_r4", '0, '0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
